// File: rtl/game_evt_pkg.sv
// rtl/game_evt_pkg.sv - shared types and event-id constants for game_event_scheduler
package game_evt_pkg;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_DYING     = 2'd1,
    ST_GAME_OVER = 2'd2
  } game_state_e;

  // Number ids start at EVT_NUM_BASE; operand and water ids are offsets past the last number id.
  localparam int EVT_NUM_BASE = 0;
  localparam int EVT_OP_BASE  = 0;
  localparam int EVT_WATER    = 2;

  function automatic int evt_id_width(input int numbers);
    return $clog2(numbers + 3);
  endfunction

endpackage

// File: rtl/game_event_scheduler_rr_arbiter.sv
// rtl/game_event_scheduler_rr_arbiter.sv - N-request round-robin arbiter with advance enable
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          valid_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt;
  logic [PW-1:0] gnt_idx;
  logic          found;

  // Scan starts at the pointer and wraps, so the last granted source gets lowest priority.
  always_comb begin : scan
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i && found) begin
      ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign gnt_o     = en_i ? gnt : '0;
  assign gnt_idx_o = gnt_idx;
  assign valid_o   = en_i && found;

endmodule

// File: rtl/game_event_scheduler.sv
// rtl/game_event_scheduler.sv - collision pulse serialiser, game-flow FSM and lives counter
// Optional GAME_EVT_DROP_CNT_EN builds the saturating lost-hit counter behind dropCount.
module game_event_scheduler
  import game_evt_pkg::*;
#(
  parameter int NUMBERS       = 3,
  parameter int INIT_LIVES    = 3,
  parameter int DEATH_FRAMES  = 60,
  parameter int MAX_PER_FRAME = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            startOfFrame,
  input  logic [NUMBERS-1:0]              numberHit,
  input  logic [1:0]                      operandHit,
  input  logic                            waterCollision,
  input  logic                            startBtn,
  input  logic                            evtReady,
  output logic                            evtValid,
  output logic [evt_id_width(NUMBERS)-1:0] evtId,
  output logic                            freeze,
  output logic [3:0]                      lives,
  output logic                            gameOver,
  output logic [7:0]                      dropCount
);

  localparam int NSRC = NUMBERS + 3;
  localparam int NRR  = NUMBERS + 2;
  localparam int WIDX = NUMBERS + EVT_WATER;
  localparam int IW   = evt_id_width(NUMBERS);
  localparam int PW   = (NRR > 1) ? $clog2(NRR) : 1;
  localparam int CW   = $clog2(MAX_PER_FRAME + 1);
  localparam int DW   = $clog2(DEATH_FRAMES + 1);

  game_state_e   state_q;
  logic [NSRC-1:0] pend_q;
  logic [CW-1:0] frame_cnt_q;
  logic [DW-1:0] death_cnt_q;
  logic          water_flag_q;
  logic          evt_valid_q;
  logic [IW-1:0] evt_id_q;
  logic          freeze_q;
  logic          game_over_q;
  logic [3:0]    lives_q;

  logic            playing, slot_free, cap_ok, water_gnt, water_set, rr_en, rr_valid, restart;
  logic [NRR-1:0]  rr_gnt;
  logic [PW-1:0]   rr_idx;
  logic [NSRC-1:0] pulses, gnt_all;

  assign playing   = (state_q == ST_PLAY);
  assign slot_free = !evt_valid_q || evtReady;
  assign cap_ok    = (frame_cnt_q != CW'(MAX_PER_FRAME));
  assign water_gnt = playing && slot_free && pend_q[WIDX];
  assign rr_en     = playing && slot_free && !pend_q[WIDX] && cap_ok;
  assign water_set = waterCollision && !water_flag_q;
  assign pulses    = playing ? {water_set, operandHit, numberHit} : '0;
  assign gnt_all   = {water_gnt, rr_gnt};
  assign restart   = (state_q == ST_GAME_OVER) && startBtn;

  rr_arbiter #(.N(NRR), .PW(PW)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (restart),
    .en_i      (rr_en),
    .req_i     (pend_q[NRR-1:0]),
    .gnt_o     (rr_gnt),
    .gnt_idx_o (rr_idx),
    .valid_o   (rr_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      pend_q       <= '0;
      frame_cnt_q  <= '0;
      death_cnt_q  <= '0;
      water_flag_q <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      freeze_q     <= 1'b0;
      game_over_q  <= 1'b0;
      lives_q      <= 4'(INIT_LIVES);
    end else begin
      if (slot_free) evt_valid_q <= 1'b0;
      if (water_gnt) begin
        evt_valid_q <= 1'b1;
        evt_id_q    <= IW'(WIDX);
      end else if (rr_valid) begin
        evt_valid_q <= 1'b1;
        evt_id_q    <= IW'(EVT_NUM_BASE + int'(rr_idx));
      end

      // A pulse landing on a source in its grant cycle keeps the bit set for a second event.
      pend_q      <= (pend_q & ~gnt_all) | pulses;
      frame_cnt_q <= startOfFrame ? CW'(rr_valid) : frame_cnt_q + CW'(rr_valid);

      if (startOfFrame)                    water_flag_q <= 1'b0;
      else if (playing && waterCollision)  water_flag_q <= 1'b1;

      case (state_q)
        ST_PLAY: begin
          if (water_gnt) begin
            pend_q   <= '0;
            freeze_q <= 1'b1;
            if (lives_q > 4'd1) begin
              state_q     <= ST_DYING;
              lives_q     <= lives_q - 4'd1;
              death_cnt_q <= '0;
            end else begin
              state_q     <= ST_GAME_OVER;
              lives_q     <= 4'd0;
              game_over_q <= 1'b1;
            end
          end
        end
        ST_DYING: begin
          if (startOfFrame) begin
            if (death_cnt_q == DW'(DEATH_FRAMES - 1)) begin
              state_q  <= ST_PLAY;
              freeze_q <= 1'b0;
            end else begin
              death_cnt_q <= death_cnt_q + DW'(1);
            end
          end
        end
        ST_GAME_OVER: begin
          if (startBtn) begin
            state_q     <= ST_PLAY;
            lives_q     <= 4'(INIT_LIVES);
            pend_q      <= '0;
            freeze_q    <= 1'b0;
            game_over_q <= 1'b0;
          end
        end
        default: state_q <= ST_PLAY;
      endcase
    end
  end

`ifdef GAME_EVT_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      drop_cnt_q <= 8'd0;
    end else if (|(pulses & pend_q & ~gnt_all) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign dropCount = drop_cnt_q;
`else
  assign dropCount = 8'd0;
`endif

  assign evtValid = evt_valid_q;
  assign evtId    = evt_id_q;
  assign freeze   = freeze_q;
  assign lives    = lives_q;
  assign gameOver = game_over_q;

endmodule

// File: tb/tb_game_event_scheduler.sv
// tb/tb_game_event_scheduler.sv - directed self-checking bench for game_event_scheduler
module tb_game_event_scheduler;

  logic       clk = 1'b0;
  logic       reset, startOfFrame, waterCollision, startBtn, evtReady;
  logic [2:0] numberHit;
  logic [1:0] operandHit;
  logic       evtValid, freeze, gameOver;
  logic [2:0] evtId;
  logic [3:0] lives;
  logic [7:0] dropCount;

  int checks = 0;
  int errors = 0;
  int n_evt, n_water;

  always #5 clk = ~clk;

  game_event_scheduler #(
    .NUMBERS(3), .INIT_LIVES(3), .DEATH_FRAMES(60), .MAX_PER_FRAME(2)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .numberHit(numberHit),
    .operandHit(operandHit), .waterCollision(waterCollision), .startBtn(startBtn),
    .evtReady(evtReady), .evtValid(evtValid), .evtId(evtId), .freeze(freeze),
    .lives(lives), .gameOver(gameOver), .dropCount(dropCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic death();
    waterCollision = 1'b1;
    step();
    step();
    step();
    waterCollision = 1'b0;
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; waterCollision = 1'b0; startBtn = 1'b0;
    evtReady = 1'b1; numberHit = '0; operandHit = '0;
    do_reset();

    check("rst_valid", evtValid, 0);
    check("rst_id", evtId, 0);
    check("rst_lives", lives, 3);
    check("rst_freeze", freeze, 0);
    check("rst_gameover", gameOver, 0);
    check("rst_drop", dropCount, 0);

    // Single hit latency
    numberHit = 3'b010;
    step();
    numberHit = '0;
    check("lat_e0_valid", evtValid, 0);
    step();
    check("lat_e1_valid", evtValid, 1);
    check("lat_e1_id", evtId, 1);
    step();
    check("lat_after_valid", evtValid, 0);

    // Round-robin plus frame cap
    do_reset();
    numberHit = 3'b101; operandHit = 2'b01;
    step();
    numberHit = '0; operandHit = '0;
    step();
    check("cap_first", {evtValid, evtId}, {1'b1, 3'd0});
    step();
    check("cap_second", {evtValid, evtId}, {1'b1, 3'd2});
    step();
    check("cap_blocked", evtValid, 0);
    step();
    check("cap_blocked2", evtValid, 0);
    sof();
    check("cap_sof_edge", evtValid, 0);
    step();
    check("cap_third", {evtValid, evtId}, {1'b1, 3'd3});
    step();
    check("cap_idle", evtValid, 0);

    // Back-pressure: pointer now at 4, so id 0 then id 1
    sof();
    evtReady = 1'b0;
    numberHit = 3'b011;
    step();
    numberHit = '0;
    step();
    check("stall_first", {evtValid, evtId}, {1'b1, 3'd0});
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), {evtValid, evtId}, {1'b1, 3'd0});
    end
    evtReady = 1'b1;
    step();
    check("stall_next", {evtValid, evtId}, {1'b1, 3'd1});
    step();
    check("stall_idle", evtValid, 0);

    // Water held for 100 cycles in one frame
    sof();
    n_evt = 0; n_water = 0;
    waterCollision = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (evtValid) n_evt++;
      if (evtValid && evtId == 3'd5) n_water++;
      if (i == 1) check("water_edge", {evtValid, evtId, lives, freeze}, {1'b1, 3'd5, 4'd2, 1'b1});
    end
    waterCollision = 1'b0;
    check("water_events", n_evt, 1);
    check("water_id5", n_water, 1);
    check("water_lives", lives, 2);
    check("water_freeze", freeze, 1);

    n_evt = 0;
    numberHit = 3'b111; operandHit = 2'b11;
    step();
    numberHit = '0; operandHit = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (evtValid) n_evt++;
    end
    check("dying_no_events", n_evt, 0);
    for (int i = 0; i < 59; i++) begin
      sof();
      step();
    end
    check("dying_59", freeze, 1);
    sof();
    check("dying_60_freeze", freeze, 0);

    // Second death, then startBtn is ignored while dying
    death();
    check("death2_lives", lives, 1);
    startBtn = 1'b1;
    step();
    startBtn = 1'b0;
    check("dying_btn_lives", {lives, freeze}, {4'd1, 1'b1});
    for (int i = 0; i < 60; i++) sof();
    check("death2_resume", freeze, 0);

    // Third death: game over, then restart
    death();
    check("over_lives", lives, 0);
    check("over_flag", {gameOver, freeze}, {1'b1, 1'b1});
    step();
    startBtn = 1'b1;
    step();
    startBtn = 1'b0;
    check("restart_lives", lives, 3);
    check("restart_flags", {gameOver, freeze}, {1'b0, 1'b0});
    sof();
    numberHit = 3'b101;
    step();
    numberHit = '0;
    step();
    check("restart_ptr", {evtValid, evtId}, {1'b1, 3'd0});
    step();
    check("restart_second", {evtValid, evtId}, {1'b1, 3'd2});

    // Lost hits while the slot is occupied
    do_reset();
    evtReady = 1'b0;
    numberHit = 3'b010;
    step();
    numberHit = 3'b001;
    step();
    check("drop_slot", {evtValid, evtId}, {1'b1, 3'd1});
    numberHit = 3'b001;
    step();
    numberHit = '0;
`ifdef GAME_EVT_DROP_CNT_EN
    check("drop_count", dropCount, 1);
`else
    check("drop_count", dropCount, 0);
`endif
    check("drop_hold", {evtValid, evtId}, {1'b1, 3'd1});
    evtReady = 1'b1;
    step();
    check("drop_drain", {evtValid, evtId}, {1'b1, 3'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
